// File: rtl/mem_delay_model.sv
// Behavioural memory with fixed read/write latency: one operation at a time,
// requests arriving while an operation is in flight are dropped and flagged.
module mem_delay_model #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 5,
    parameter int WR_LAT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enable,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_enable,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err_drop,
    output logic [1:0]        dbg_state
);

    if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
        $error("mem_delay_model: RD_LAT must be in 1..255");
    end
    if (WR_LAT < 1 || WR_LAT > 255) begin : g_bad_wr_lat
        $error("mem_delay_model: WR_LAT must be in 1..255");
    end

    localparam logic [7:0] RD_CNT = 8'(RD_LAT);
    localparam logic [7:0] WR_CNT = 8'(WR_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_q, err_d;
    logic              mem_we;
    logic              rd_load;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Valid/ready contract: a request is taken only when busy=0 at the edge;
    // there is no backpressure beyond busy, so a refused request is lost and
    // reported on err_drop in the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        rd_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_enable) begin
                    state_d = WRITE;
                    cnt_d   = WR_CNT;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    err_d   = rd_enable;
                end else if (rd_enable) begin
                    state_d = READ;
                    cnt_d   = RD_CNT;
                    addr_d  = rd_addr;
                end
            end
            WRITE, READ: begin
                err_d = wr_enable | rd_enable;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    mem_we  = (state_q == WRITE);
                    rd_load = (state_q == READ);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_load;
            if (rd_load) begin
                rd_data_q <= mem_q[addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Array is never reset so contents survive rst; a write cut by rst is lost.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign err_drop  = err_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_delay_model.sv
// Bench for mem_delay_model: default, short-latency and narrow-address instances.
module tb_mem_delay_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_we, a_re, a_valid, a_busy, a_err;
    logic [7:0]  a_wa, a_ra;
    logic [15:0] a_wd, a_rd;
    logic [1:0]  a_st;

    logic        b_we, b_re, b_valid, b_busy, b_err;
    logic [7:0]  b_wa, b_ra;
    logic [15:0] b_wd, b_rd;
    logic [1:0]  b_st;

    logic        c_we, c_re, c_valid, c_busy, c_err;
    logic [3:0]  c_wa, c_ra;
    logic [15:0] c_wd, c_rd;
    logic [1:0]  c_st;

    mem_delay_model u_a (
        .clk(clk), .rst(rst), .wr_enable(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rd_enable(a_re), .rd_addr(a_ra), .rd_data(a_rd), .rd_valid(a_valid),
        .busy(a_busy), .err_drop(a_err), .dbg_state(a_st)
    );

    mem_delay_model #(.RD_LAT(1), .WR_LAT(3)) u_b (
        .clk(clk), .rst(rst), .wr_enable(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .rd_enable(b_re), .rd_addr(b_ra), .rd_data(b_rd), .rd_valid(b_valid),
        .busy(b_busy), .err_drop(b_err), .dbg_state(b_st)
    );

    mem_delay_model #(.ADDR_W(4)) u_c (
        .clk(clk), .rst(rst), .wr_enable(c_we), .wr_addr(c_wa), .wr_data(c_wd),
        .rd_enable(c_re), .rd_addr(c_ra), .rd_data(c_rd), .rd_valid(c_valid),
        .busy(c_busy), .err_drop(c_err), .dbg_state(c_st)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference for instance A: an operation accepted at
    // edge n finishes at edge n+LAT; anything arriving before then is dropped.
    localparam int LAT_A = 5;
    logic [15:0] mdl_mem [256];
    bit          mdl_known [256];
    int          edge_n = 0;
    bit          pend = 0;
    bit          pend_wr;
    logic [7:0]  pend_addr;
    logic [15:0] pend_data;
    int          done_at;
    logic        exp_busy, exp_valid, exp_err;
    logic [15:0] exp_rdata = '0;
    bit          exp_rdata_known = 0;

    task automatic tick();
        bit was_busy;
        was_busy  = pend;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst) begin
            pend            = 0;
            exp_rdata       = '0;
            exp_rdata_known = 1;
        end else if (was_busy) begin
            exp_err = a_we | a_re;
            if (edge_n == done_at) begin
                pend = 0;
                if (pend_wr) begin
                    mdl_mem[pend_addr]   = pend_data;
                    mdl_known[pend_addr] = 1;
                end else begin
                    exp_valid       = 1'b1;
                    exp_rdata       = mdl_mem[pend_addr];
                    exp_rdata_known = mdl_known[pend_addr];
                end
            end
        end else if (a_we) begin
            pend = 1; pend_wr = 1; pend_addr = a_wa; pend_data = a_wd;
            done_at = edge_n + LAT_A;
            exp_err = a_re;
        end else if (a_re) begin
            pend = 1; pend_wr = 0; pend_addr = a_ra;
            done_at = edge_n + LAT_A;
        end
        exp_busy = pend;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic a_read(input logic [7:0] addr);
        a_re = 1'b1; a_ra = addr;
        tick();
        a_re = 1'b0;
        repeat (LAT_A) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_we = 1'b1; a_re = 1'b1; a_wa = 8'h33; a_ra = 8'h33; a_wd = 16'hDEAD;
        b_we = 1'b1; b_re = 1'b1; c_we = 1'b1; c_re = 1'b1;
        tick(); tick();
        n_vec++; if ({a_busy, a_valid, a_err} !== 3'b000) begin n_err++;
            $display("FAIL reset_a_flags got %b want 000", {a_busy, a_valid, a_err}); end
        n_vec++; if (a_rd !== 16'h0) begin n_err++;
            $display("FAIL reset_a_rdata got %h want 0000", a_rd); end
        n_vec++; if ({a_st, b_st, c_st} !== 6'b0) begin n_err++;
            $display("FAIL reset_state got %b want 000000", {a_st, b_st, c_st}); end
        n_vec++; if ({b_busy, b_err, c_busy, c_err} !== 4'b0) begin n_err++;
            $display("FAIL reset_bc_flags got %b want 0000", {b_busy, b_err, c_busy, c_err}); end
        n_vec++; if ({b_rd, c_rd} !== 32'h0) begin n_err++;
            $display("FAIL reset_bc_rdata got %h want 0", {b_rd, c_rd}); end
        rst = 1'b0;
        a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0; c_we = 1'b0; c_re = 1'b0;
        tick();
        n_vec++; if ({a_busy, a_err, b_err, c_err} !== 4'b0) begin n_err++;
            $display("FAIL reset_no_accept got %b want 0000", {a_busy, a_err, b_err, c_err}); end
    endtask

    task automatic test_write_read();
        a_we = 1'b1; a_wa = 8'h10; a_wd = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            tick();
            a_we = 1'b0;
            n_vec++; if (a_busy !== (i < 5)) begin n_err++;
                $display("FAIL wr_busy edge %0d got %b want %b", i, a_busy, (i < 5)); end
        end
        a_re = 1'b1; a_ra = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            a_re = 1'b0;
            n_vec++; if (a_valid !== 1'b0) begin n_err++;
                $display("FAIL rd_early_valid edge %0d got %b want 0", i, a_valid); end
        end
        tick();
        n_vec++; if ({a_valid, a_rd} !== {1'b1, 16'h1234}) begin n_err++;
            $display("FAIL rd_result got v=%b d=%h want v=1 d=1234", a_valid, a_rd); end
        tick();
        n_vec++; if ({a_valid, a_rd} !== {1'b0, 16'h1234}) begin n_err++;
            $display("FAIL rd_hold got v=%b d=%h want v=0 d=1234", a_valid, a_rd); end
    endtask

    task automatic test_drop_during_write();
        for (int i = 0; i < 6; i++) begin
            a_we = (i == 0); a_wa = 8'h11; a_wd = 16'hC0DE;
            a_re = (i == 2); a_ra = 8'h10;
            tick();
            n_vec++; if ({a_busy, a_err, a_valid} !== {(i < 5), (i == 2), 1'b0}) begin n_err++;
                $display("FAIL drop_wr edge %0d got b/e/v=%b want %b", i,
                         {a_busy, a_err, a_valid}, {(i < 5), (i == 2), 1'b0}); end
        end
        a_re = 1'b0;
        a_read(8'h11);
        n_vec++; if ({a_valid, a_rd} !== {1'b1, 16'hC0DE}) begin n_err++;
            $display("FAIL drop_wr_commit got v=%b d=%h want v=1 d=c0de", a_valid, a_rd); end
    endtask

    task automatic test_collision();
        a_we = 1'b1; a_re = 1'b1; a_wa = 8'h12; a_wd = 16'h7777; a_ra = 8'h13;
        for (int i = 0; i < 6; i++) begin
            tick();
            a_we = 1'b0; a_re = 1'b0;
            n_vec++; if ({a_busy, a_err, a_valid} !== {(i < 5), (i == 0), 1'b0}) begin n_err++;
                $display("FAIL collide edge %0d got b/e/v=%b want %b", i,
                         {a_busy, a_err, a_valid}, {(i < 5), (i == 0), 1'b0}); end
        end
        a_read(8'h12);
        n_vec++; if ({a_valid, a_rd} !== {1'b1, 16'h7777}) begin n_err++;
            $display("FAIL collide_data got v=%b d=%h want v=1 d=7777", a_valid, a_rd); end
    endtask

    task automatic test_reset_abort();
        a_we = 1'b1; a_wa = 8'h20; a_wd = 16'h5A5A;
        tick();
        a_we = 1'b0;
        repeat (LAT_A) tick();
        a_we = 1'b1; a_wd = 16'hBEEF;
        tick();
        a_we = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({a_busy, a_valid, a_err} !== 3'b000) begin n_err++;
            $display("FAIL wr_abort_flags got %b want 000", {a_busy, a_valid, a_err}); end
        repeat (4) tick();
        a_read(8'h20);
        n_vec++; if ({a_valid, a_rd} !== {1'b1, 16'h5A5A}) begin n_err++;
            $display("FAIL wr_abort_data got v=%b d=%h want v=1 d=5a5a", a_valid, a_rd); end
        a_re = 1'b1; a_ra = 8'h11;
        tick();
        a_re = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({a_busy, a_rd} !== {1'b0, 16'h0}) begin n_err++;
            $display("FAIL rd_abort got b=%b d=%h want b=0 d=0000", a_busy, a_rd); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (a_valid !== 1'b0) begin n_err++;
                $display("FAIL rd_abort_valid cyc %0d got %b want 0", i, a_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b_last;
        logic [15:0] want;
        b_last = 16'h0;
        for (int k = 0; k < 12; k++) begin
            b_we = 1'b1; b_wa = 8'(k); b_wd = 16'h0100 + 16'(k);
            tick();
            n_vec++; if ({b_busy, b_err, b_valid} !== {((k % 4) != 3), ((k % 4) != 0), 1'b0}) begin
                n_err++;
                $display("FAIL b2b_wr edge %0d got b/e/v=%b want %b", k, {b_busy, b_err, b_valid},
                         {((k % 4) != 3), ((k % 4) != 0), 1'b0}); end
        end
        b_we = 1'b0;
        tick();
        n_vec++; if ({b_busy, b_err} !== 2'b00) begin n_err++;
            $display("FAIL b2b_gap got %b want 00", {b_busy, b_err}); end
        for (int j = 0; j < 6; j++) begin
            b_re = 1'b1; b_ra = 8'((j / 2) * 4);
            tick();
            if (j % 2 == 1) begin
                want   = 16'h0100 + 16'((j / 2) * 4);
                b_last = want;
            end else begin
                want = b_last;
            end
            n_vec++; if ({b_busy, b_err, b_valid, b_rd} !== {(j % 2 == 0), (j % 2 == 1), (j % 2 == 1), want}) begin
                n_err++;
                $display("FAIL b2b_rd edge %0d got b/e/v=%b d=%h want %b d=%h", j,
                         {b_busy, b_err, b_valid}, b_rd, {(j % 2 == 0), (j % 2 == 1), (j % 2 == 1)}, want); end
        end
        b_re = 1'b0;
        tick();
    endtask

    task automatic test_small_addr();
        c_we = 1'b1; c_wa = 4'h0; c_wd = 16'hAAAA;
        tick(); c_we = 1'b0; repeat (5) tick();
        c_we = 1'b1; c_wa = 4'hF; c_wd = 16'h5555;
        tick(); c_we = 1'b0; repeat (5) tick();
        n_vec++; if (c_busy !== 1'b0) begin n_err++;
            $display("FAIL small_idle got %b want 0", c_busy); end
        c_re = 1'b1; c_ra = 4'h0;
        tick(); c_re = 1'b0; repeat (5) tick();
        n_vec++; if ({c_valid, c_rd} !== {1'b1, 16'hAAAA}) begin n_err++;
            $display("FAIL small_addr0 got v=%b d=%h want v=1 d=aaaa", c_valid, c_rd); end
        c_re = 1'b1; c_ra = 4'hF;
        tick(); c_re = 1'b0; repeat (5) tick();
        n_vec++; if ({c_valid, c_rd} !== {1'b1, 16'h5555}) begin n_err++;
            $display("FAIL small_addrf got v=%b d=%h want v=1 d=5555", c_valid, c_rd); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom_range(0, 99) < 2);
            a_we = ($urandom_range(0, 9) < 3);
            a_re = ($urandom_range(0, 9) < 3);
            a_wa = 8'($urandom_range(0, 31));
            a_ra = 8'($urandom_range(0, 31));
            a_wd = 16'($urandom);
            tick();
            n_vec++; if ({a_busy, a_err, a_valid} !== {exp_busy, exp_err, exp_valid}) begin n_err++;
                $display("FAIL rand_flags cyc %0d got b/e/v=%b want %b", k,
                         {a_busy, a_err, a_valid}, {exp_busy, exp_err, exp_valid}); end
            if (exp_rdata_known) begin
                n_vec++; if (a_rd !== exp_rdata) begin n_err++;
                    $display("FAIL rand_rdata cyc %0d got %h want %h", k, a_rd, exp_rdata); end
            end
        end
        rst = 1'b0; a_we = 1'b0; a_re = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        a_we = 1'b0; a_re = 1'b0; a_wa = '0; a_ra = '0; a_wd = '0;
        b_we = 1'b0; b_re = 1'b0; b_wa = '0; b_ra = '0; b_wd = '0;
        c_we = 1'b0; c_re = 1'b0; c_wa = '0; c_ra = '0; c_wd = '0;
        test_reset();
        test_write_read();
        test_drop_during_write();
        test_collision();
        test_reset_abort();
        test_back_to_back();
        test_small_addr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
